// File: rtl/rsa_result_serializer.sv
// Captures a 256-bit exponentiation result on the rising edge of the core's level valid
// and streams it MSB byte first over a valid/ready byte interface.
module rsa_result_serializer #(
    parameter int BUS_WIDTH     = 256,
    parameter int BYTE_COUNT    = 32,
    parameter int COUNTER_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BUS_WIDTH-1:0] result_in,
    input  logic                 result_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(BYTE_COUNT - 1);

    state_t                 state_r, state_s;
    logic [BUS_WIDTH-1:0]   shreg_r, shreg_s;
    logic [COUNTER_WIDTH-1:0] cnt_r, cnt_s;
    logic                   valid_d_r;
    logic                   overrun_r, overrun_s;
    logic [7:0]             tx_data_r, tx_data_s;
    logic                   tx_valid_r, tx_valid_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   new_res_s;
    logic                   handshake_s;

    assign new_res_s   = result_valid & ~valid_d_r;
    assign handshake_s = tx_valid_r & tx_ready;

    // Next-state, datapath and next-output logic
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        cnt_s     = cnt_r;
        overrun_s = overrun_r;
        case (state_r)
            ST_IDLE: begin
                if (new_res_s) begin
                    shreg_s = result_in;
                    cnt_s   = {COUNTER_WIDTH{1'b0}};
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (new_res_s) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                if (handshake_s) begin
                    shreg_s = {shreg_r[BUS_WIDTH-9:0], 8'h00};
                    cnt_s   = cnt_r + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                if (new_res_s) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        tx_valid_s = (state_s == ST_SEND);
        busy_s     = (state_s == ST_SEND);
        done_s     = (state_s == ST_DONE);
        if (state_s == ST_SEND) begin
            tx_data_s = shreg_s[BUS_WIDTH-1 -: 8];
        end else begin
            tx_data_s = 8'h00;
        end
    end

    // State, datapath and output registers; valid_d resets high to ignore a stale valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            shreg_r    <= {BUS_WIDTH{1'b0}};
            cnt_r      <= {COUNTER_WIDTH{1'b0}};
            valid_d_r  <= 1'b1;
            overrun_r  <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            cnt_r      <= cnt_s;
            valid_d_r  <= result_valid;
            overrun_r  <= overrun_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overrun  = overrun_r;

endmodule
